tensor_core_register_file_drain: RTL and testbench
==================================================

// Module: tensor_core_register_file_drain
// PURPOSE
//  Read-side streamer for the tensor core register file. On start it snapshots the bulk read bus
//  (2 matrices x 3x3 signed elements) into a local buffer, then emits the selected elements one per
//  accepted beat on a valid/ready stream (row-major, matrix 0 first), e.g. to a UART/host bridge.
//  Because of the snapshot, the register file may be bulk-written or reset while a drain is in flight.
// PARAMETERS
//  DATA_WIDTH    8  element width in bits, signed two's complement
//  MATRIX_DIM    3  rows = cols per matrix
//  NUM_MATRICES  2  matrices in the register file
// PORTS
//  clock_in            in   1             single clock, rising edge
//  reset_n_in          in   1             asynchronous, active-low reset
//  start_in            in   1             request a drain; sampled only in IDLE
//  mode_in             in   2             0 = matrix 0 (9 elems), 1 = matrix 1 (9), 2 = both (18), 3 = illegal
//  bulk_read_data_in   in   8 x[2][3][3]  from the register file's bulk read output
//  data_out            out  8             current element, signed
//  index_out           out  5             flat address of data_out = n*9 + i*3 + j (0..17)
//  valid_out           out  1             data_out/index_out/last_out are valid
//  ready_in            in   1             sink accepts the beat when valid_out && ready_in
//  last_out            out  1             current beat is the final one of this drain
//  busy_out            out  1             state != IDLE
//  done_out            out  1             one-cycle pulse after the final beat is accepted
//  error_out           out  1             one-cycle pulse when start_in arrives with mode_in == 3
// BEHAVIOUR
//  Reset (async assert, sync deassert at the board level): state = IDLE; all outputs 0; index and
//   buffer cleared. Reset mid-drain aborts immediately; the partial stream is not resumed.
//  FSM states: IDLE, STREAM, DONE.
//  IDLE: on start_in with mode_in in {0,1,2}:
//   - capture all 18 elements into the buffer;
//   - index <= (mode_in == 1) ? 9 : 0;  end <= (mode_in == 0) ? 8 : 17;
//   - go to STREAM.
//  IDLE, start_in with mode_in == 3: error_out = 1 for one cycle; stay in IDLE; buffer unchanged.
//  STREAM: valid_out = 1; data_out = buf[index]; last_out = (index == end).
//   - On valid_out && ready_in: if last_out, go to DONE; else index++.
//   - Latency: first beat is valid the cycle after start_in is sampled.
//   - With ready_in held high, throughput is one element per cycle, and a 9-element drain is done
//     10 cycles after start_in.
//  Stream rule: while valid_out && !ready_in, data_out, index_out and last_out hold stable.
//   valid_out never drops before acceptance.
//  DONE: done_out = 1 and valid_out = 0 for exactly one cycle, then go to IDLE. A new start is
//   first sampled in that IDLE cycle, so two back-to-back drains have a 2-cycle gap between streams.
//  start_in in STREAM/DONE is ignored, not queued. Changes on bulk_read_data_in after capture
//   have no effect on the current drain.
//  Arithmetic:
//   - index is 5 bits and never exceeds 17; there is no wrap-around.
//   - Elements pass through bit-exact, with no sign extension or truncation.
// STRUCTURE
//  tensor_core_pkg (shared with the register file and tensor core):
//   - DATA_WIDTH, MATRIX_DIM, NUM_MATRICES, NUM_ELEMENTS = 18, ADDR_WIDTH = 5;
//   - typedef logic signed [DATA_WIDTH-1:0] element_t;
//   - enum drain_mode_e {DRAIN_M0, DRAIN_M1, DRAIN_BOTH};
//   - enum drain_state_e {IDLE, STREAM, DONE}.
//  Single module, no sub-module. The snapshot buffer is a flat element_t [18] register array
//   indexed by the flat address, using the same n*9 + i*3 + j mapping as the register file's
//   non-bulk address.
// TESTING
//  1. Fill matrix 0 with 1..9, pulse start with mode 0, ready high
//     -> beats 1..9 on consecutive cycles, index 0..8, last only on 9, done 1 cycle later.
//  2. Fill matrix 1 with -1..-9 (0xFF..0xF7), start with mode 2, ready toggling 1,0,1,0
//     -> 18 beats, indices 0..17; each held stable while ready is low; sign bits exact.
//  3. Start with mode 1, then overwrite the register file with 0x55 during beat 3
//     -> all 9 beats carry the original values; index 9..17.
//  4. Start with mode 3 -> error_out pulses once; busy_out, valid_out and done_out stay 0.
//  5. Assert reset_n_in low after the 4th accepted beat
//     -> valid_out, busy_out and last_out go 0 asynchronously; after release a mode-0 start
//        streams from index 0.
//  6. Pulse start_in again during STREAM and during DONE -> ignored; exactly one drain is emitted.

Source files
------------

// File: rtl/tensor_core_register_file_drain_pkg.sv
// Shared tensor core definitions: element type, register file geometry and drain enums.
package tensor_core_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned MATRIX_DIM      = 3;
  localparam int unsigned NUM_MATRICES    = 2;
  localparam int unsigned MATRIX_ELEMENTS = MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned NUM_ELEMENTS    = NUM_MATRICES * MATRIX_ELEMENTS;
  localparam int unsigned ADDR_WIDTH      = 5;

  typedef logic signed [DATA_WIDTH-1:0] element_t;

  typedef enum logic [1:0] {
    DRAIN_M0   = 2'd0,
    DRAIN_M1   = 2'd1,
    DRAIN_BOTH = 2'd2
  } drain_mode_e;

  localparam logic [1:0] DRAIN_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } drain_state_e;

endpackage

// File: rtl/tensor_core_register_file_drain.sv
// Snapshots the register file's bulk read bus on start, then streams the selected
// elements row-major over a valid/ready interface with registered outputs.
module tensor_core_register_file_drain
  import tensor_core_pkg::*;
(
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic [1:0]            mode_in,
  input  logic [NUM_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_read_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] index_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

  localparam logic [ADDR_WIDTH-1:0] M1_FIRST = ADDR_WIDTH'(MATRIX_ELEMENTS);
  localparam logic [ADDR_WIDTH-1:0] M0_LAST  = ADDR_WIDTH'(MATRIX_ELEMENTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALL_LAST = ADDR_WIDTH'(NUM_ELEMENTS - 1);

  drain_state_e          state;
  element_t              buffer [NUM_ELEMENTS];
  logic [ADDR_WIDTH-1:0] end_index;
  logic [ADDR_WIDTH-1:0] next_index;
  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] bulk_flat;
  element_t              first_element;

  // Packed [n][i][j] flattens so element n*9+i*3+j sits at bit offset (n*9+i*3+j)*DATA_WIDTH.
  assign bulk_flat  = bulk_read_data_in;
  assign next_index = index_out + 1'b1;

  always_comb begin
    first_element = element_t'(bulk_flat[DATA_WIDTH-1:0]);
    if (mode_in == DRAIN_M1) begin
      first_element = element_t'(bulk_flat[MATRIX_ELEMENTS*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= IDLE;
      index_out <= '0;
      end_index <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      error_out <= 1'b0;
      for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
        buffer[k[ADDR_WIDTH-1:0]] <= '0;
      end
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            if (mode_in == DRAIN_ILLEGAL) begin
              error_out <= 1'b1;
            end else begin
              for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
                buffer[k[ADDR_WIDTH-1:0]] <= element_t'(bulk_flat[k*DATA_WIDTH +: DATA_WIDTH]);
              end
              // First beat comes straight from the bus so it is valid the cycle after start.
              index_out <= (mode_in == DRAIN_M1) ? M1_FIRST : '0;
              end_index <= (mode_in == DRAIN_M0) ? M0_LAST : ALL_LAST;
              data_out  <= first_element;
              valid_out <= 1'b1;
              last_out  <= 1'b0;
              busy_out  <= 1'b1;
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (ready_in) begin
            if (last_out) begin
              valid_out <= 1'b0;
              last_out  <= 1'b0;
              done_out  <= 1'b1;
              state     <= DONE;
            end else begin
              index_out <= next_index;
              data_out  <= buffer[next_index];
              last_out  <= (next_index == end_index);
            end
          end
        end
        DONE: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_register_file_drain.sv
// Directed and randomized drains checked against a snapshot/queue reference model.
module tb_tensor_core_register_file_drain;

  logic       clock_in = 1'b0;
  logic       reset_n_in;
  logic       start_in;
  logic [1:0] mode_in;
  logic       ready_in;
  logic [1:0][2:0][2:0][7:0] bulk_read_data_in;
  logic [7:0] data_out;
  logic [4:0] index_out;
  logic       valid_out;
  logic       last_out;
  logic       busy_out;
  logic       done_out;
  logic       error_out;

  int errors = 0;
  int checks = 0;

  tensor_core_register_file_drain dut (
    .clock_in          (clock_in),
    .reset_n_in        (reset_n_in),
    .start_in          (start_in),
    .mode_in           (mode_in),
    .bulk_read_data_in (bulk_read_data_in),
    .data_out          (data_out),
    .index_out         (index_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .last_out          (last_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .error_out         (error_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_busy"},  busy_out,  0);
    check({tag, "_done"},  done_out,  0);
    check({tag, "_last"},  last_out,  0);
  endtask

  // Runs one drain from the negedge it is called on; returns on a negedge.
  task automatic drain(input int mode, input int rmode, input int corrupt_beat,
                       input int reset_beat, input bit restart);
    logic [7:0] snap [18];
    int first, last_i, n, beat, cycles;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          snap[m*9 + i*3 + j] = bulk_read_data_in[m][i][j];
    first  = (mode == 1) ? 9 : 0;
    last_i = (mode == 0) ? 8 : 17;
    n      = last_i - first + 1;
    start_in = 1'b1;
    mode_in  = 2'(mode);
    ready_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0;
    beat   = 0;
    cycles = 0;
    while (beat < n && cycles < 200) begin
      if (reset_beat >= 0 && beat == reset_beat) begin
        reset_n_in = 1'b0;
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_busy",  busy_out,  0);
        check("rst_last",  last_out,  0);
        return;
      end
      case (rmode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cycles % 2 == 0);
        default: ready_in = 1'($urandom_range(1, 0));
      endcase
      start_in = restart && (cycles == 2);
      if (restart) mode_in = 2'd2;
      check("valid", valid_out, 1);
      check("busy",  busy_out,  1);
      check("done_in_stream", done_out, 0);
      check("data",  data_out,  snap[first + beat]);
      check("index", index_out, first + beat);
      check("last",  last_out,  (beat == n - 1));
      if (ready_in) begin
        beat++;
        if (beat == corrupt_beat) bulk_read_data_in = {18{8'h55}};
      end
      cycles++;
      @(negedge clock_in);
    end
    start_in = 1'b0;
    check("beats_before_timeout", beat, n);
    if (rmode == 0) check("stream_cycles", cycles, n);
    check("done_pulse", done_out, 1);
    check("done_valid", valid_out, 0);
    check("done_busy",  busy_out,  1);
    check("done_last",  last_out,  0);
    start_in = restart;
    @(negedge clock_in);
    start_in = 1'b0;
    check_idle("after_done");
    @(negedge clock_in);
    check_idle("no_queued_start");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_in = 1'b0;
    start_in   = 1'b0;
    mode_in    = 2'd0;
    ready_in   = 1'b0;
    bulk_read_data_in = '0;
    @(negedge clock_in);
    check_idle("reset");
    check("reset_error", error_out, 0);
    check("reset_index", index_out, 0);
    check("reset_data",  data_out,  0);
    reset_n_in = 1'b1;
    @(negedge clock_in);

    // Matrix 0 = 1..9, ready held high.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        bulk_read_data_in[0][i][j] = 8'(i*3 + j + 1);
    drain(0, 0, -1, -1, 1'b0);

    // Matrix 1 = -1..-9, both matrices, ready toggling.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        bulk_read_data_in[1][i][j] = 8'(-(i*3 + j + 1));
    drain(2, 1, -1, -1, 1'b0);

    // Matrix 1 only; bus overwritten with 0x55 mid-drain.
    drain(1, 0, 3, -1, 1'b0);

    // Illegal mode.
    start_in = 1'b1;
    mode_in  = 2'd3;
    @(negedge clock_in);
    start_in = 1'b0;
    check("err_pulse", error_out, 1);
    check_idle("err");
    @(negedge clock_in);
    check("err_single", error_out, 0);
    check_idle("err_after");

    // Reset after the 4th accepted beat, then a fresh mode-0 drain.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          bulk_read_data_in[m][i][j] = 8'($urandom);
    drain(2, 2, -1, 4, 1'b0);
    @(negedge clock_in);
    check_idle("held_reset");
    check("held_reset_index", index_out, 0);
    reset_n_in = 1'b1;
    @(negedge clock_in);
    drain(0, 2, -1, -1, 1'b0);

    // Start pulsed during STREAM and DONE must be ignored.
    drain(0, 0, -1, -1, 1'b1);

    // Randomized drains.
    for (int r = 0; r < 4; r++) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            bulk_read_data_in[m][i][j] = 8'($urandom);
      drain(int'($urandom_range(2, 0)), 2, -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
